f1_start_seq: RTL and testbench
===============================

# f1_start_seq

Parametrised F1 start-light sequencer with reaction timing. It fills an N-light bar one lamp per step strobe, then holds all lamps lit for a delay supplied from outside (typically an LFSR). It then extinguishes the bar, measures the player's reaction time in clock cycles, and flags a jump-start. It sits between the step-strobe / random-delay sources and the light bar and score display.

## Interface
Parameters:
- N_LIGHTS, 8, number of lamps in the bar (≥2)
- DELAY_W, 7, width of the hold-delay input, in ticks
- REACT_W, 16, width of the reaction-time counter, in clock cycles

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- trigger  in  1  start request; honoured only in IDLE
- tick  in  1  one-cycle step strobe; paces the fill and the hold
- delay  in  DELAY_W  hold length in ticks; sampled once, when the bar becomes full
- stop  in  1  player button; level-sampled every cycle
- data_out  out  N_LIGHTS  lamp bar; bit 0 lights first
- lights_out  out  1  one-cycle pulse when the bar goes dark at race start
- react_time  out  REACT_W  last measured reaction time
- react_valid  out  1  react_time holds a valid result
- false_start  out  1  stop was seen before lights-out
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, FILL, HOLD, TIMING. All outputs are registered.
- Reset (rst=0, asynchronous): state IDLE. data_out, react_time, lights_out, react_valid, false_start, busy, the delay counter and the reaction counter are all 0.
- IDLE:
  - data_out=0.
  - trigger=1 → FILL. Clears react_valid and false_start. react_time keeps its value.
  - A tick or stop in the same cycle is ignored.
- FILL:
  - Each tick: data_out <= {data_out[N_LIGHTS-2:0],1'b1}.
  - On the tick that makes data_out all-ones, load dcnt<=delay and go to HOLD.
  - Exactly N_LIGHTS ticks fill the bar.
- HOLD:
  - Each tick: if dcnt==0, then data_out<=0, lights_out<=1 for one cycle, rcnt<=0, go to TIMING. Otherwise dcnt<=dcnt-1.
  - Lights-out happens on the (delay+1)-th tick after the filling tick. delay=0 means the first tick after fill.
- TIMING:
  - rcnt increments every clk cycle; tick is ignored.
  - rcnt saturates at 2^REACT_W−1 and stays in TIMING.
  - stop=1: react_time<=rcnt, react_valid<=1, go to IDLE.
- False start: stop=1 in FILL or HOLD causes data_out<=0, false_start<=1, react_valid stays 0, go to IDLE. stop has priority over a tick in the same cycle.
- trigger outside IDLE is ignored.
- Asserting rst mid-sequence aborts immediately to reset values. No pending result survives reset.

## Timing
- trigger at edge k: busy=1 and state FILL after edge k. The first lamp lights on the first tick sampled after edge k.
- data_out changes on the edge that samples the tick.
- lights_out is high for exactly the first TIMING cycle; rcnt=0 in that cycle.
- A stop sampled in the first TIMING cycle gives react_time=0. A stop sampled m cycles later gives react_time=m.
- react_time and react_valid update on the edge sampling stop. busy falls on that same edge.
- False-start flags update on the edge sampling stop.

## Test plan
- Reset mid-HOLD (N_LIGHTS=8): assert rst asynchronously between edges → all outputs 0 immediately, state IDLE. After release, a trigger restarts cleanly.
- Normal run (N_LIGHTS=8, delay=3): trigger, then 8 ticks → data_out 01,03,…,FF. Ticks 9,10,11 keep FF. Tick 12 → data_out=00 and lights_out pulses once. stop 5 cycles after the pulse cycle → react_time=5, react_valid=1, busy=0.
- Edge delays: delay=0 → lights-out on the first tick after FF. delay=2^DELAY_W−1 → exactly 128 hold ticks.
- False start: stop at the same cycle as the 4th tick in FILL → data_out=00 with no 4th lamp, false_start=1, react_valid=0. Repeat in HOLD. A new trigger clears false_start.
- Saturation (REACT_W=4): no stop for 20 cycles after lights-out → rcnt holds 15. stop → react_time=15.
- Ignored inputs: trigger in FILL/HOLD/TIMING has no effect. stop in IDLE has no effect. tick in TIMING does not alter rcnt.

Source files
------------

// File: rtl/f1_start_seq.sv
// F1 start-light sequencer: fills the lamp bar, holds for an external
// delay, goes dark, then times the player's reaction or flags a jump-start.
module f1_start_seq #(
  parameter int N_LIGHTS = 8,
  parameter int DELAY_W  = 7,
  parameter int REACT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic                tick,
  input  logic [DELAY_W-1:0]  delay,
  input  logic                stop,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                lights_out,
  output logic [REACT_W-1:0]  react_time,
  output logic                react_valid,
  output logic                false_start,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD,
    TIMING
  } state_e;

  localparam logic [REACT_W-1:0] RMAX = '1;

  state_e              state_q, state_d;
  logic [N_LIGHTS-1:0] data_q, data_d;
  logic [DELAY_W-1:0]  dcnt_q, dcnt_d;
  logic [REACT_W-1:0]  rcnt_q, rcnt_d;
  logic [REACT_W-1:0]  rtime_q, rtime_d;
  logic                rvalid_q, rvalid_d;
  logic                fstart_q, fstart_d;
  logic                lout_q, lout_d;
  logic                busy_q, busy_d;

  // Next-state and registered-output logic for the start sequence.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    dcnt_d   = dcnt_q;
    rcnt_d   = rcnt_q;
    rtime_d  = rtime_q;
    rvalid_d = rvalid_q;
    fstart_d = fstart_q;
    lout_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        data_d = '0;
        if (trigger) begin
          state_d  = FILL;
          rvalid_d = 1'b0;
          fstart_d = 1'b0;
        end
      end
      FILL: begin
        if (stop) begin
          data_d   = '0;
          fstart_d = 1'b1;
          state_d  = IDLE;
        end else if (tick) begin
          data_d = {data_q[N_LIGHTS-2:0], 1'b1};
          if (&data_q[N_LIGHTS-2:0]) begin
            dcnt_d  = delay;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (stop) begin
          data_d   = '0;
          fstart_d = 1'b1;
          state_d  = IDLE;
        end else if (tick) begin
          if (dcnt_q == '0) begin
            data_d  = '0;
            lout_d  = 1'b1;
            rcnt_d  = '0;
            state_d = TIMING;
          end else begin
            dcnt_d = dcnt_q - 1'b1;
          end
        end
      end
      TIMING: begin
        if (stop) begin
          rtime_d  = rcnt_q;
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end else if (rcnt_q != RMAX) begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      dcnt_q   <= '0;
      rcnt_q   <= '0;
      rtime_q  <= '0;
      rvalid_q <= 1'b0;
      fstart_q <= 1'b0;
      lout_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      dcnt_q   <= dcnt_d;
      rcnt_q   <= rcnt_d;
      rtime_q  <= rtime_d;
      rvalid_q <= rvalid_d;
      fstart_q <= fstart_d;
      lout_q   <= lout_d;
      busy_q   <= busy_d;
    end
  end

  assign data_out    = data_q;
  assign lights_out  = lout_q;
  assign react_time  = rtime_q;
  assign react_valid = rvalid_q;
  assign false_start = fstart_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_f1_start_seq.sv
// Bench for f1_start_seq: directed scenarios plus random traffic,
// all checked against a lamp-count / elapsed-time reference model.
module tb_f1_start_seq;

  localparam int N  = 8;
  localparam int DW = 7;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          trigger = 1'b0;
  logic          tick = 1'b0;
  logic          stop = 1'b0;
  logic [DW-1:0] delay = '0;
  logic [N-1:0]  data_out;
  logic          lights_out;
  logic [RW-1:0] react_time;
  logic          react_valid;
  logic          false_start;
  logic          busy;

  f1_start_seq #(
    .N_LIGHTS(N),
    .DELAY_W (DW),
    .REACT_W (RW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trigger    (trigger),
    .tick       (tick),
    .delay      (delay),
    .stop       (stop),
    .data_out   (data_out),
    .lights_out (lights_out),
    .react_time (react_time),
    .react_valid(react_valid),
    .false_start(false_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // reference model: lamps lit, hold ticks seen, cycles since lights-out
  int m_active, m_racing, m_lit, m_hold, m_delay, m_elapsed, m_pulse;
  int e_time, e_valid, e_false;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_racing = 0; m_lit = 0; m_hold = 0;
    m_delay = 0; m_elapsed = 0; m_pulse = 0;
    e_time = 0; e_valid = 0; e_false = 0;
  endtask

  task automatic model_edge(input bit tg, input bit tk, input bit st,
                            input int dl);
    m_pulse = 0;
    if (!m_active) begin
      if (tg) begin
        m_active = 1; m_racing = 0; m_lit = 0;
        e_valid = 0; e_false = 0;
      end
    end else if (m_racing) begin
      if (st) begin
        e_time = (m_elapsed > (1 << RW) - 1) ? (1 << RW) - 1 : m_elapsed;
        e_valid = 1;
        m_active = 0; m_racing = 0;
      end else begin
        m_elapsed++;
      end
    end else if (st) begin
      m_active = 0; m_lit = 0; e_false = 1;
    end else if (tk) begin
      if (m_lit < N) begin
        m_lit++;
        if (m_lit == N) begin
          m_delay = dl; m_hold = 0;
        end
      end else begin
        m_hold++;
        if (m_hold == m_delay + 1) begin
          m_racing = 1; m_lit = 0; m_elapsed = 0; m_pulse = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    int exp_data;
    exp_data = (m_active != 0 && m_racing == 0) ? (1 << m_lit) - 1 : 0;
    chk("data_out", 32'(data_out), 32'(exp_data));
    chk("lights_out", 32'(lights_out), 32'(m_pulse));
    chk("react_time", 32'(react_time), 32'(e_time));
    chk("react_valid", 32'(react_valid), 32'(e_valid));
    chk("false_start", 32'(false_start), 32'(e_false));
    chk("busy", 32'(busy), 32'(m_active));
  endtask

  task automatic cyc(input bit tg, input bit tk, input bit st,
                     input int dl);
    trigger = tg; tick = tk; stop = st; delay = DW'(dl);
    @(posedge clk);
    model_edge(tg, tk, st, dl);
    #1;
    check_all();
  endtask

  task automatic fill_bar(input int dl);
    cyc(1, 0, 0, dl);
    for (int i = 0; i < N; i++) begin
      cyc(0, 1, 0, dl);
      cyc(0, 0, 0, dl);
    end
  endtask

  initial begin
    int cnt;
    int pstop;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 0, 0);

    // normal run, delay 3, reaction 5
    cyc(1, 0, 0, 3);
    chk("trig_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= N; i++) begin
      cyc(0, 1, 0, 3);
      chk("fill_lamps", 32'(data_out), 32'((1 << i) - 1));
      cyc(1, 0, 0, 3);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      chk("hold_full", 32'(data_out), 32'hFF);
    end
    cyc(0, 1, 0, 0);
    chk("lo_pulse", 32'(lights_out), 32'd1);
    chk("lo_dark", 32'(data_out), 32'd0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    chk("norm_rt", 32'(react_time), 32'd5);
    chk("norm_rv", 32'(react_valid), 32'd1);
    chk("norm_busy", 32'(busy), 32'd0);
    cyc(0, 1, 1, 0);

    // delay 0: dark on first tick after full
    fill_bar(0);
    cyc(0, 1, 0, 0);
    chk("d0_lo", 32'(lights_out), 32'd1);
    cyc(0, 0, 1, 0);
    chk("d0_rt", 32'(react_time), 32'd0);

    // max delay: 128 hold ticks
    fill_bar(127);
    cnt = 0;
    for (int i = 0; i < 300 && !lights_out; i++) begin
      cyc(0, 1, 0, 0);
      cnt++;
    end
    chk("dmax_ticks", 32'(cnt), 32'd128);

    // saturation after 20 idle cycles
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    chk("sat_rt", 32'(react_time), 32'd15);

    // false start in fill on the 4th tick
    cyc(1, 0, 0, 2);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 2);
    cyc(0, 1, 1, 2);
    chk("fs_fill_d", 32'(data_out), 32'd0);
    chk("fs_fill_f", 32'(false_start), 32'd1);
    chk("fs_fill_v", 32'(react_valid), 32'd0);

    // false start in hold, then cleared by trigger
    fill_bar(5);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    chk("fs_hold_f", 32'(false_start), 32'd1);
    cyc(1, 0, 0, 0);
    chk("fs_clear", 32'(false_start), 32'd0);

    // async reset mid-hold, then clean restart
    for (int i = 0; i < N; i++) cyc(0, 1, 0, 9);
    cyc(0, 1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_data", 32'(data_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    fill_bar(1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("restart_lo", 32'(lights_out), 32'd1);
    cyc(0, 0, 1, 0);

    // random traffic
    for (int blk = 0; blk < 3; blk++) begin
      pstop = (blk == 0) ? 200 : (blk == 1) ? 40 : 10;
      for (int i = 0; i < 1500; i++) begin
        cyc(($urandom % 8) == 0, ($urandom % 2) == 1,
            ($urandom % pstop) == 0,
            (($urandom % 10) == 0) ? 127 : int'($urandom_range(0, 6)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
